mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 35 +++
 rtl/mdu_ctrl_md_calc.sv | 55 +++++
 rtl/mdu_ctrl.sv | 103 ++++++++++
 tb/tb_mdu_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_ctrl_pkg                                                          |
// | Shared MD opcode encodings, latency defaults and FSM state type.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W        = 8;

  // True for the opcodes that occupy the unit for multiple cycles.
  function automatic logic is_md_arith(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_md_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_calc                                                               |
// | Combinational 64-bit multiply and 32-bit divide/remainder.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module md_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, uq, ur, udq, udr, sq, sr;
  logic               a_neg, b_neg, b_zero;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};
  assign b_zero = (b_i == 32'd0);

  // Signed divide works on magnitudes so -2^31 / -1 stays well defined.
  assign a_neg = a_i[31];
  assign b_neg = b_i[31];
  assign a_mag = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag = b_neg ? (~b_i + 32'd1) : b_i;
  assign uq    = b_zero ? 32'd0 : (a_mag / b_mag);
  assign ur    = b_zero ? 32'd0 : (a_mag % b_mag);
  assign sq    = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign sr    = a_neg ? (~ur + 32'd1) : ur;
  assign udq   = b_zero ? 32'd0 : (a_i / b_i);
  assign udr   = b_zero ? 32'd0 : (a_i % b_i);

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    wr_o = 1'b0;
    case (op_i)
      MD_MULT:  begin hi_o = prod_s[63:32]; lo_o = prod_s[31:0]; wr_o = 1'b1; end
      MD_MULTU: begin hi_o = prod_u[63:32]; lo_o = prod_u[31:0]; wr_o = 1'b1; end
      MD_DIV:   begin hi_o = sr;  lo_o = sq;  wr_o = !b_zero; end
      MD_DIVU:  begin hi_o = udr; lo_o = udq; wr_o = !b_zero; end
      default:  ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_ctrl                                                              |
// | Multiply/divide unit control: FSM, latency counter, HI/LO registers. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYC);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;
  logic [31:0]      calc_hi, calc_lo;
  logic             calc_wr;

  md_calc u_md_calc (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_o (calc_hi),
    .lo_o (calc_lo),
    .wr_o (calc_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_md_arith(md_op)) begin
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
              cnt_q   <= (md_op == MD_MULT || md_op == MD_MULTU) ? MULT_CNT : DIV_CNT;
              op_q    <= md_op;
              a_q     <= rs_val;
              b_q     <= rt_val;
            end else if (md_op == MD_MTHI) begin
              hi_q <= rs_val;
            end else if (md_op == MD_MTLO) begin
              lo_q <= rs_val;
            end
          end
        end
        S_BUSY: begin
          // The result lands on the edge that ends the final busy cycle.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (calc_wr) begin
              hi_q <= calc_hi;
              lo_q <= calc_lo;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall_md = md_use_d & (busy_q | (start & is_md_arith(md_op)));

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// Testbench for mdu_ctrl: directed scenarios plus randomized ops against
// an arithmetic reference model of HI/LO and busy timing.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, md_use_d;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d),
    .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: new {hi,lo} after an arithmetic op completes.
  task automatic model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    case (op)
      1: begin q = sa * sb; exp_hi = q[63:32]; exp_lo = q[31:0]; end
      2: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      4: if (b != 0) begin p = ua / ub; exp_lo = p[31:0]; p = ua % ub; exp_hi = p[31:0]; end
      5: exp_hi = a;
      6: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op from IDLE and follow it to completion; poke adds an
  // ignored start (with md_use_d) part way through the busy window.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    int   ncyc;
    logic use_now, exp_stall;
    logic [31:0] old_hi, old_lo;
    old_hi  = exp_hi;
    old_lo  = exp_lo;
    ncyc    = (op == 1 || op == 2) ? 5 : ((op == 3 || op == 4) ? 10 : 0);
    use_now = 1'($urandom_range(0, 1));
    start = 1'b1; md_op = 3'(op); rs_val = a; rt_val = b; md_use_d = use_now;
    #1;
    exp_stall = use_now && (ncyc != 0);
    n_checks++;
    if (stall_md !== exp_stall) begin
      n_fail++;
      $display("FAIL stall_at_start op=%0d: got %b want %b", op, stall_md, exp_stall);
    end
    @(posedge clk); #1;
    start = 1'b0; md_use_d = 1'b0; md_op = 3'd0;
    for (int i = 0; i < ncyc; i++) begin
      n_checks++;
      if (busy !== 1'b1 || hi !== old_hi || lo !== old_lo) begin
        n_fail++;
        $display("FAIL busy_window op=%0d cyc=%0d: busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                 op, i, busy, hi, lo, old_hi, old_lo);
      end
      if (poke && i == 1) begin
        start = 1'b1; md_op = 3'($urandom_range(0, 7)); rs_val = $urandom; rt_val = $urandom;
        md_use_d = 1'b1;
        #1;
        n_checks++;
        if (stall_md !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_while_busy: got %b want 1", stall_md);
        end
      end
      @(posedge clk); #1;
      start = 1'b0; md_use_d = 1'b0; md_op = 3'd0;
    end
    model(op, a, b);
    n_checks++;
    if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL result op=%0d a=%h b=%h: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
               op, a, b, busy, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; md_op = 3'd1; rs_val = 32'd9; rt_val = 32'd9; md_use_d = 1'b0;
    tick(); tick();
    reset = 1'b0; start = 1'b0; md_op = 3'd0; md_use_d = 1'b1;
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h want 0/0/0/0", busy, stall_md, hi, lo);
    end
    md_use_d = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_with_start: busy=%b want 0", busy);
    end
  endtask

  task automatic test_mult();
    do_op(1, 32'hFFFFFFFE, 32'd3, 1'b0);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      n_fail++;
      $display("FAIL mult_const: hi=%h lo=%h want ffffffff fffffffa", hi, lo);
    end
    do_op(2, 32'hFFFFFFFE, 32'd3, 1'b0);
    n_checks++;
    if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
      n_fail++;
      $display("FAIL multu_const: hi=%h lo=%h want 00000002 fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    do_op(3, 32'hFFFFFFF9, 32'd2, 1'b0);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++;
      $display("FAIL div_const: hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    do_op(4, 32'd7, 32'd0, 1'b0);
    n_checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_fail++;
      $display("FAIL divu_by_zero: hi=%h lo=%h want unchanged ffffffff fffffffd", hi, lo);
    end
  endtask

  task automatic test_stall();
    logic exp_s;
    start = 1'b1; md_op = 3'd1; rs_val = 32'd6; rt_val = 32'd7; md_use_d = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      #1;
      exp_s = (k <= 5);
      n_checks++;
      if (stall_md !== exp_s) begin
        n_fail++;
        $display("FAIL stall_seq cyc=%0d: got %b want %b", k, stall_md, exp_s);
      end
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
    end
    md_use_d = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd42;
    n_checks++;
    if (lo !== 32'd42 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_product: hi=%h lo=%h want 0 2a", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    do_op(5, 32'h12345678, 32'd0, 1'b0);
    n_checks++;
    if (hi !== 32'h12345678 || lo !== 32'd42) begin
      n_fail++;
      $display("FAIL mthi: hi=%h lo=%h want 12345678 0000002a", hi, lo);
    end
    start = 1'b1; md_op = 3'd2; rs_val = 32'd2; rt_val = 32'd5;
    tick();
    start = 1'b1; md_op = 3'd6; rs_val = 32'hDEADBEEF;
    tick();
    start = 1'b0; md_op = 3'd0;
    for (int i = 0; i < 6; i++) tick();
    exp_hi = 32'd0; exp_lo = 32'd10;
    n_checks++;
    if (lo !== 32'd10 || hi !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mtlo_in_busy: hi=%h lo=%h busy=%b want 0 a 0", hi, lo, busy);
    end
  endtask

  task automatic test_ignored_ops();
    do_op(7, 32'hAAAA5555, 32'd1, 1'b0);
    do_op(0, 32'h5555AAAA, 32'd1, 1'b0);
  endtask

  task automatic test_reset_busy();
    do_op(1, 32'h00010001, 32'h00030007, 1'b0);
    start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_no_late_write: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 5));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op(op, a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; md_use_d = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mthi_mtlo();
    test_ignored_ops();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
